// File: rtl/dcache_pkg.sv
// Shared types and address-slicing helpers for the direct-mapped data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      GAP,
      REFILL
   } state_e;

   localparam int OFFSET_W = 5;
   localparam int LINE_W   = 256;

   // Helpers return a full 32-bit value; callers size-cast to their index/tag width.
   function automatic logic [31:0] idx_of(input logic [31:0] addr, input int idx_w);
      return (addr >> OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] addr, input int idx_w);
      return addr >> (OFFSET_W + idx_w);
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty/tag/data per line, combinational read port, one write port.
// Line write (refill) takes priority over word write (store hit); valid/dirty clear on reset.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int LINES = 16,
   parameter int IDX_W = 4,
   parameter int TAG_W = 23
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic              vld_o,
   output logic              dty_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic [LINE_W-1:0] line_o,
   input  logic              line_we_i,
   input  logic [TAG_W-1:0]  line_tag_i,
   input  logic [LINE_W-1:0] line_dat_i,
   input  logic              word_we_i,
   input  logic [2:0]        word_sel_i,
   input  logic [31:0]       word_dat_i
);

   logic [LINES-1:0]  valid_q, valid_d;
   logic [LINES-1:0]  dirty_q, dirty_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [TAG_W-1:0]  tag_d  [LINES];
   logic [LINE_W-1:0] data_q [LINES];
   logic [LINE_W-1:0] data_d [LINES];

   assign vld_o  = valid_q[idx_i];
   assign dty_o  = dirty_q[idx_i];
   assign tag_o  = tag_q[idx_i];
   assign line_o = data_q[idx_i];

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (line_we_i) begin
         valid_d[idx_i] = 1'b1;
         dirty_d[idx_i] = 1'b0;
         tag_d[idx_i]   = line_tag_i;
         data_d[idx_i]  = line_dat_i;
      end else if (word_we_i) begin
         dirty_d[idx_i] = 1'b1;
         data_d[idx_i][{word_sel_i, 5'b0} +: 32] = word_dat_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tag and data contents are meaningless until valid is set, so they carry no reset.
   always_ff @(posedge clk_i) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache: hits answer in 0 cycles, misses stall the
// CPU through optional dirty write-back, a one-cycle gap, and a line refill on a level/ack bus.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int LINES      = 16,
   parameter int LINE_BYTES = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [31:0]             p1_addr_i,
   input  logic [31:0]             p1_data_i,
   input  logic                    p1_MemRead_i,
   input  logic                    p1_MemWrite_i,
   output logic [31:0]             p1_data_o,
   output logic                    p1_stall_o,
   output logic                    mem_enable_o,
   output logic                    mem_write_o,
   output logic [31:0]             mem_addr_o,
   output logic [LINE_BYTES*8-1:0] mem_data_o,
   input  logic [LINE_BYTES*8-1:0] mem_data_i,
   input  logic                    mem_ack_i
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 32 - OFFSET_W - IDX_W;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  req_tag;
   logic [2:0]        word_sel;
   logic              unused_addr_bits;

   logic              arr_vld, arr_dty;
   logic [TAG_W-1:0]  arr_tag;
   logic [LINE_W-1:0] arr_line;

   logic              req, hit, word_we, line_we;

   state_e            state_q, state_d;
   logic              mem_enable_q, mem_enable_d;
   logic              mem_write_q, mem_write_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0] mem_data_q, mem_data_d;

   assign idx              = IDX_W'(idx_of(p1_addr_i, IDX_W));
   assign req_tag          = TAG_W'(tag_of(p1_addr_i, IDX_W));
   assign word_sel         = p1_addr_i[4:2];
   assign unused_addr_bits = ^p1_addr_i[1:0];

   dcache_array #(
      .LINES (LINES),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_array (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .idx_i      (idx),
      .vld_o      (arr_vld),
      .dty_o      (arr_dty),
      .tag_o      (arr_tag),
      .line_o     (arr_line),
      .line_we_i  (line_we),
      .line_tag_i (req_tag),
      .line_dat_i (mem_data_i),
      .word_we_i  (word_we),
      .word_sel_i (word_sel),
      .word_dat_i (p1_data_i)
   );

   assign req     = p1_MemRead_i | p1_MemWrite_i;
   assign hit     = (state_q == IDLE) && arr_vld && (arr_tag == req_tag);
   assign word_we = hit && p1_MemWrite_i;
   assign line_we = (state_q == REFILL) && mem_ack_i;

   // The CPU holds its request during the stall, so the refilled line hits on return to IDLE.
   assign p1_stall_o = (state_q != IDLE) || (req && !hit);
   assign p1_data_o  = hit ? arr_line[{word_sel, 5'b0} +: 32] : 32'd0;

   always_comb begin
      state_d      = state_q;
      mem_enable_d = mem_enable_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      case (state_q)
         IDLE: begin
            if (req && !hit) begin
               mem_enable_d = 1'b1;
               mem_data_d   = arr_line;
               if (arr_vld && arr_dty) begin
                  state_d     = WRITEBACK;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {arr_tag, idx, {OFFSET_W{1'b0}}};
               end else begin
                  state_d     = REFILL;
                  mem_write_d = 1'b0;
                  mem_addr_d  = {req_tag, idx, {OFFSET_W{1'b0}}};
               end
            end
         end
         WRITEBACK: begin
            if (mem_ack_i) begin
               state_d      = GAP;
               mem_enable_d = 1'b0;
            end
         end
         GAP: begin
            state_d      = REFILL;
            mem_enable_d = 1'b1;
            mem_write_d  = 1'b0;
            mem_addr_d   = {req_tag, idx, {OFFSET_W{1'b0}}};
         end
         REFILL: begin
            if (mem_ack_i) begin
               state_d      = IDLE;
               mem_enable_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         mem_enable_q <= mem_enable_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
      end
   end

   assign mem_enable_o = mem_enable_q;
   assign mem_write_o  = mem_write_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios then random traffic against a word-level memory view
// and a line-residency model; a bench-side memory answers the level/ack bus.
module tb_dcache_ctrl;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [31:0]  p1_addr_i, p1_data_i;
   logic         p1_MemRead_i, p1_MemWrite_i;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;
   logic         mem_enable_o, mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o, mem_data_i;
   logic         mem_ack_i;

   always #5 clk_i = ~clk_i;

   dcache_ctrl #(.LINES(16), .LINE_BYTES(32)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .p1_addr_i     (p1_addr_i),
      .p1_data_i     (p1_data_i),
      .p1_MemRead_i  (p1_MemRead_i),
      .p1_MemWrite_i (p1_MemWrite_i),
      .p1_data_o     (p1_data_o),
      .p1_stall_o    (p1_stall_o),
      .mem_enable_o  (mem_enable_o),
      .mem_write_o   (mem_write_o),
      .mem_addr_o    (mem_addr_o),
      .mem_data_o    (mem_data_o),
      .mem_data_i    (mem_data_i),
      .mem_ack_i     (mem_ack_i)
   );

   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] data;
      int           start;
      int           ackc;
   } txn_t;

   txn_t         log_q[$];
   logic [255:0] bmem [logic [26:0]];
   logic [31:0]  cpu_view [logic [31:0]];
   int           ack_dly = 1;
   int           spur_cyc = -1;
   int           cyc = 0;
   int           n_chk = 0;
   int           n_pass = 0;
   bit           m_valid [16];
   bit           m_dirty [16];
   logic [22:0]  m_tag [16];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'h5A00_0000;
   endfunction

   function automatic logic [255:0] get_line(input logic [26:0] ln);
      logic [255:0] l;
      if (bmem.exists(ln)) return bmem[ln];
      for (int w = 0; w < 8; w++) begin
         logic [2:0] ws;
         ws = w[2:0];
         l[w*32 +: 32] = init_word({ln, ws, 2'b00});
      end
      return l;
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] a);
      logic [255:0] l;
      if (cpu_view.exists(a)) return cpu_view[a];
      l = get_line(a[31:5]);
      return l[{a[4:2], 5'b0} +: 32];
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Bench-side memory: acks after ack_dly cycles of enable, one-cycle pulse.
   initial begin
      int   cnt;
      int   start_c;
      txn_t t;
      cnt = 0;
      start_c = 0;
      mem_ack_i = 1'b0;
      mem_data_i = '0;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            cnt = 0;
         end else if (cyc == spur_cyc) begin
            mem_ack_i = 1'b1;
         end else if (mem_enable_o) begin
            if (cnt == 0) start_c = cyc;
            cnt++;
            if (cnt >= ack_dly) begin
               mem_ack_i = 1'b1;
               t.wr = mem_write_o;
               t.addr = mem_addr_o;
               t.start = start_c;
               t.ackc = cyc;
               if (mem_write_o) begin
                  bmem[mem_addr_o[31:5]] = mem_data_o;
                  t.data = mem_data_o;
               end else begin
                  mem_data_i = get_line(mem_addr_o[31:5]);
                  t.data = mem_data_i;
               end
               log_q.push_back(t);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Called at a falling edge; returns at a falling edge with the command dropped.
   task automatic cpu_op(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] wdat, input int dly, output logic [31:0] rdata);
      logic [3:0]  idx;
      logic [22:0] tag;
      logic [31:0] wa, exp_rd, vaddr;
      bit          hit, wb;
      int          n0, stalls, exp_stall, exp_n;
      wa = {addr[31:2], 2'b00};
      idx = addr[8:5];
      tag = addr[31:9];
      hit = m_valid[idx] && (m_tag[idx] == tag);
      wb = !hit && m_valid[idx] && m_dirty[idx];
      vaddr = {m_tag[idx], idx, 5'b0};
      exp_stall = hit ? 0 : (wb ? 2 + 2 * dly : 1 + dly);
      exp_n = hit ? 0 : (wb ? 2 : 1);
      exp_rd = model_word(wa);
      ack_dly = dly;
      n0 = log_q.size();
      p1_addr_i = addr;
      p1_data_i = wdat;
      p1_MemRead_i = rd;
      p1_MemWrite_i = wr;
      stalls = 0;
      #1;
      while (p1_stall_o !== 1'b0 && stalls < 100) begin
         stalls++;
         @(negedge clk_i);
         #1;
      end
      rdata = p1_data_o;
      @(posedge clk_i);
      @(negedge clk_i);
      p1_MemRead_i = 1'b0;
      p1_MemWrite_i = 1'b0;
      check("stall_cycles", stalls, exp_stall);
      check("mem_txn_count", log_q.size() - n0, exp_n);
      if (rd) check("read_data", rdata, exp_rd);
      if (wb && log_q.size() >= n0 + 2) begin
         check("wb_is_write", log_q[n0].wr, 1);
         check("wb_addr", log_q[n0].addr, vaddr);
         check("gap_one_cycle", log_q[n0+1].start - log_q[n0].ackc, 2);
      end
      if (!hit && log_q.size() >= n0 + exp_n) begin
         check("refill_is_read", log_q[n0+exp_n-1].wr, 0);
         check("refill_addr", log_q[n0+exp_n-1].addr, {addr[31:5], 5'b0});
      end
      m_dirty[idx] = hit ? (m_dirty[idx] | wr) : wr;
      m_valid[idx] = 1'b1;
      m_tag[idx] = tag;
      if (wr) cpu_view[wa] = wdat;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]  rdata;
      logic [255:0] l;
      int           n0;
      logic [31:0]  a, d;
      int           op;
      rst_i = 1'b0;
      p1_addr_i = '0;
      p1_data_i = '0;
      p1_MemRead_i = 1'b0;
      p1_MemWrite_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i] = '0;
      end
      l = get_line(27'd2);
      l[95:64] = 32'hDEAD_BEEF;
      bmem[27'd2] = l;

      repeat (3) @(negedge clk_i);
      #1;
      check("rst_stall", p1_stall_o, 0);
      check("rst_enable", mem_enable_o, 0);
      check("rst_write", mem_write_o, 0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_mem_data", mem_data_o, 0);
      check("rst_p1_data", p1_data_o, 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);

      cpu_op(1'b0, 1'b1, 32'h40, 32'h0, 3, rdata);
      cpu_op(1'b0, 1'b1, 32'h48, 32'h0, 3, rdata);
      check("fill_word2", rdata, 32'hDEAD_BEEF);

      cpu_op(1'b1, 1'b0, 32'h44, 32'h1234_5678, 3, rdata);
      cpu_op(1'b0, 1'b1, 32'h44, 32'h0, 3, rdata);
      check("write_hit_readback", rdata, 32'h1234_5678);

      n0 = log_q.size();
      cpu_op(1'b0, 1'b1, 32'h240, 32'h0, 2, rdata);
      if (log_q.size() >= n0 + 2) check("wb_word1", log_q[n0].data[63:32], 32'h1234_5678);

      cpu_op(1'b1, 1'b0, 32'h80, 32'hA5A5_A5A5, 1, rdata);
      n0 = log_q.size();
      cpu_op(1'b0, 1'b1, 32'h280, 32'h0, 2, rdata);
      if (log_q.size() >= n0 + 2) check("wb_merge_word0", log_q[n0].data[31:0], 32'hA5A5_A5A5);

      n0 = log_q.size();
      spur_cyc = cyc + 1;
      repeat (3) @(negedge clk_i);
      #1;
      check("spur_ack_enable", mem_enable_o, 0);
      check("spur_ack_stall", p1_stall_o, 0);
      check("spur_ack_txns", log_q.size() - n0, 0);
      @(negedge clk_i);
      cpu_op(1'b0, 1'b1, 32'h280, 32'h0, 2, rdata);

      cpu_op(1'b1, 1'b0, 32'h240, 32'h0BAD_F00D, 2, rdata);
      ack_dly = 50;
      p1_addr_i = 32'h40;
      p1_MemRead_i = 1'b1;
      #1;
      check("rstwb_detect_stall", p1_stall_o, 1);
      @(negedge clk_i);
      #1;
      check("rstwb_enable", mem_enable_o, 1);
      check("rstwb_write", mem_write_o, 1);
      check("rstwb_addr", mem_addr_o, 32'h240);
      check("rstwb_data_word0", mem_data_o[31:0], 32'h0BAD_F00D);
      rst_i = 1'b0;
      p1_MemRead_i = 1'b0;
      @(negedge clk_i);
      #1;
      check("rstwb_after_enable", mem_enable_o, 0);
      check("rstwb_after_stall", p1_stall_o, 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      cpu_view.delete();
      cpu_op(1'b0, 1'b1, 32'h40, 32'h0, 2, rdata);
      cpu_op(1'b0, 1'b1, 32'h240, 32'h0, 2, rdata);
      check("lost_dirty_data", rdata, init_word(32'h240));

      for (int i = 0; i < 400; i++) begin
         a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
         d = $urandom;
         op = $urandom_range(0, 9);
         if (op < 5)      cpu_op(1'b0, 1'b1, a, d, $urandom_range(1, 4), rdata);
         else if (op < 9) cpu_op(1'b1, 1'b0, a, d, $urandom_range(1, 4), rdata);
         else             cpu_op(1'b1, 1'b1, a, d, $urandom_range(1, 4), rdata);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
